// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package prefetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Small synchronous FIFO with push/pop/clear, occupancy count and head output.
module pq_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order buffering, redirect flush.
// Optional PREFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [CW-1:0] tag_count;
    logic [SW-1:0] credits_used;
    fetch_entry_t  q_head;
    fetch_entry_t  q_push_data;
    logic [31:0]   tag_head;
    logic          accept;
    logic          resp;
    logic          resp_keep;
    logic          bypass_hit;
    logic          bypass_take;
    logic          q_push;
    logic          q_pop;
    logic          unused_ok;

    assign unused_ok = ^{redirect_pc[1:0], tag_count};

    assign credits_used = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req     = !reset && !redirect_valid && (credits_used < SW'(DEPTH));
    assign imem_addr    = fetch_pc;
    assign accept       = imem_req && imem_ready;

    // A response with nothing outstanding is spurious and has no tag to pair with.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign resp_keep = resp && !redirect_valid && (drop_cnt == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = resp_keep && (q_count == '0);
`else
    assign bypass_hit = 1'b0;
`endif
    assign bypass_take = bypass_hit && !stall;

    assign q_push      = resp_keep && !bypass_take;
    assign q_pop       = (q_count != '0) && !stall && !redirect_valid;
    assign q_push_data = '{instr: imem_rdata, pc: tag_head};

    pq_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_entry_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    // Request addresses in issue order; popped only by responses that are kept.
    pq_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp_keep),
        .head      (tag_head),
        .count     (tag_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old stream.
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= outstanding - CW'(resp);
            drop_cnt    <= outstanding - CW'(resp);
        end else begin
            if (accept) fetch_pc <= pc_inc(fetch_pc);
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (q_count != '0) begin
            instr_valid = 1'b1;
            instr       = q_head.instr;
            instr_pc    = q_head.pc;
        end else if (bypass_hit) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = tag_head;
        end
    end

    assign instr_pc_plus4 = pc_inc(instr_pc);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_push && (q_count == CW'(DEPTH))));
    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credits_used <= SW'(DEPTH));

endmodule
